prescaler_multi: RTL and testbench

PRESCALER_MULTI -- requirements
Module: prescaler_multi

---
 rtl/prescaler_pkg.sv | 18 +
 rtl/prescaler_chan.sv | 87 ++++++++
 rtl/prescaler_multi.sv | 57 +++++
 tb/tb_prescaler_multi.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/prescaler_pkg.sv
// Shared constants and helpers for the multi-channel prescaler.
package prescaler_pkg;

  localparam int unsigned MAX_CHANNELS = 8;
  localparam int unsigned DEF_WIDTH    = 27;
  localparam int unsigned DEF_DIV      = 100_000_000;

  // Ceiling log2, used to size the channel select.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned k = 0; k < 32; k++) begin
      if ((64'd1 << k) < 64'(n)) r = k + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/prescaler_chan.sv
// One prescaler channel: counter, shadow divide register, pending flag and
// period-boundary adoption. Optional square output under PRESCALER_SQ_EN.
module prescaler_chan
  import prescaler_pkg::*;
#(
  parameter int unsigned WIDTH       = DEF_WIDTH,
  parameter int unsigned DEFAULT_DIV = DEF_DIV
) (
  input  logic             CLK,
  input  logic             CLR_N,
  input  logic             ce,
  input  logic             sclr,
  input  logic             ld,
  input  logic [WIDTH-1:0] div_in,
  output logic             div_ack,
  output logic             pend,
  output logic             ceo_c
`ifdef PRESCALER_SQ_EN
  ,
  output logic             sq
`endif
);

  localparam logic [WIDTH-1:0] RST_DIV = WIDTH'(DEFAULT_DIV);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] div_act;
  logic [WIDTH-1:0] div_sh;
  logic [WIDTH-1:0] deff;
  logic [WIDTH-1:0] last;
  logic             term;
  logic             adopt;

  // Effective divide, terminal count (>= covers a count left beyond a newly
  // adopted shorter period) and the adoption qualifier.
  always_comb begin
    deff  = (div_act == '0) ? WIDTH'(1) : div_act;
    last  = deff - WIDTH'(1);
    term  = (cnt >= last);
    ceo_c = ce & ~sclr & term;
    adopt = pend & ~ld & (ceo_c | sclr | (~ce & (cnt == '0)));
  end

  // Period counter with synchronous clear.
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      cnt <= '0;
    end else if (sclr) begin
      cnt <= '0;
    end else if (ce) begin
      cnt <= term ? '0 : cnt + WIDTH'(1);
    end
  end

  // Shadow load and boundary adoption; a same-cycle load wins over adoption.
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      div_act <= RST_DIV;
      div_sh  <= RST_DIV;
      pend    <= 1'b0;
      div_ack <= 1'b0;
    end else begin
      div_ack <= adopt;
      if (ld) begin
        div_sh <= div_in;
        pend   <= 1'b1;
      end else if (adopt) begin
        div_act <= div_sh;
        pend    <= 1'b0;
      end
    end
  end

`ifdef PRESCALER_SQ_EN
  // Square wave toggling on every terminal-count pulse.
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      sq <= 1'b0;
    end else if (sclr) begin
      sq <= 1'b0;
    end else if (ceo_c) begin
      sq <= ~sq;
    end
  end
`endif

endmodule

// File: rtl/prescaler_multi.sv
// Multi-channel clock-enable prescaler with glitch-free divide reloads.
// Optional SQ output per channel when PRESCALER_SQ_EN is defined.
module prescaler_multi
  import prescaler_pkg::*;
#(
  parameter  int unsigned CHANNELS    = 2,
  parameter  int unsigned WIDTH       = DEF_WIDTH,
  parameter  int unsigned DEFAULT_DIV = DEF_DIV,
  localparam int unsigned SEL_W       = (CHANNELS > 1) ? clog2(CHANNELS) : 1
) (
  input  logic                CLK,
  input  logic                CLR_N,
  input  logic [CHANNELS-1:0] CE,
  input  logic [CHANNELS-1:0] SCLR,
  input  logic [WIDTH-1:0]    DIV_IN,
  input  logic [SEL_W-1:0]    DIV_SEL,
  input  logic                DIV_LD,
  output logic [CHANNELS-1:0] DIV_ACK,
  output logic [CHANNELS-1:0] PEND,
  output logic [CHANNELS-1:0] CEO
`ifdef PRESCALER_SQ_EN
  ,
  output logic [CHANNELS-1:0] SQ
`endif
);

  // Reject unsupported channel counts at elaboration.
  if (CHANNELS < 1 || CHANNELS > MAX_CHANNELS) begin : g_bad_cfg
    $error("prescaler_multi: CHANNELS out of range");
  end

  // Per-channel instances; a select beyond the last channel matches nothing.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    logic ld_i;
    assign ld_i = DIV_LD & (DIV_SEL == SEL_W'(i));

    prescaler_chan #(
      .WIDTH       (WIDTH),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .CLK     (CLK),
      .CLR_N   (CLR_N),
      .ce      (CE[i]),
      .sclr    (SCLR[i]),
      .ld      (ld_i),
      .div_in  (DIV_IN),
      .div_ack (DIV_ACK[i]),
      .pend    (PEND[i]),
      .ceo_c   (CEO[i])
`ifdef PRESCALER_SQ_EN
      ,
      .sq      (SQ[i])
`endif
    );
  end

endmodule

// File: tb/tb_prescaler_multi.sv
// Bench for prescaler_multi: directed scenarios plus randomized traffic
// checked every cycle against a behavioural model of each channel.
module tb_prescaler_multi;

  // Three channels so that a select value of 3 is representable and unused.
  localparam int unsigned CH   = 3;
  localparam int unsigned W    = 8;
  localparam int unsigned DDIV = 5;
  localparam int unsigned SW   = 2;

  logic          CLK = 1'b0;
  logic          CLR_N;
  logic [CH-1:0] CE, SCLR, DIV_ACK, PEND, CEO;
  logic [W-1:0]  DIV_IN;
  logic [SW-1:0] DIV_SEL;
  logic          DIV_LD;
`ifdef PRESCALER_SQ_EN
  logic [CH-1:0] SQ;
`endif

  prescaler_multi #(
    .CHANNELS    (CH),
    .WIDTH       (W),
    .DEFAULT_DIV (DDIV)
  ) dut (
    .CLK     (CLK),
    .CLR_N   (CLR_N),
    .CE      (CE),
    .SCLR    (SCLR),
    .DIV_IN  (DIV_IN),
    .DIV_SEL (DIV_SEL),
    .DIV_LD  (DIV_LD),
    .DIV_ACK (DIV_ACK),
    .PEND    (PEND),
    .CEO     (CEO)
`ifdef PRESCALER_SQ_EN
    ,
    .SQ      (SQ)
`endif
  );

  always #5 CLK = ~CLK;

  // Reference state per channel.
  int m_cnt [CH];
  int m_act [CH];
  int m_sh  [CH];
  bit m_pend[CH];
  bit m_ack [CH];
  bit m_sq  [CH];

  int n_cmp = 0;
  int n_bad = 0;
  logic clr_next;
  logic [CH-1:0] obs_ceo, obs_ack, obs_pend;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0d required %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      m_cnt[i]  = 0;
      m_act[i]  = DDIV;
      m_sh[i]   = DDIV;
      m_pend[i] = 1'b0;
      m_ack[i]  = 1'b0;
      m_sq[i]   = 1'b0;
    end
  endtask

  function automatic bit model_ceo(input int i);
    int deff;
    deff = (m_act[i] == 0) ? 1 : m_act[i];
    return CE[i] && !SCLR[i] && (m_cnt[i] >= deff - 1);
  endfunction

  // Advance the model by one rising edge using the currently driven inputs.
  task automatic model_edge();
    for (int i = 0; i < CH; i++) begin
      bit pulse, evt, ld_i, adopt;
      pulse = model_ceo(i);
      evt   = pulse || SCLR[i] || (!CE[i] && m_cnt[i] == 0);
      ld_i  = DIV_LD && (int'(DIV_SEL) == i);
      adopt = m_pend[i] && evt && !ld_i;
      m_ack[i] = adopt;
      if (SCLR[i]) begin
        m_cnt[i] = 0;
        m_sq[i]  = 1'b0;
      end else if (pulse) begin
        m_cnt[i] = 0;
        m_sq[i]  = !m_sq[i];
      end else if (CE[i]) begin
        m_cnt[i]++;
      end
      if (ld_i) begin
        m_sh[i]   = int'(DIV_IN);
        m_pend[i] = 1'b1;
      end else if (adopt) begin
        m_act[i]  = m_sh[i];
        m_pend[i] = 1'b0;
      end
    end
  endtask

  // Drive one cycle at the falling edge, compare, then advance the model.
  task automatic step(input logic [CH-1:0] ce, input logic [CH-1:0] sclr, input logic ld,
                      input logic [SW-1:0] sel, input logic [W-1:0] din);
    logic [CH-1:0] e_ceo, e_ack, e_pend;
`ifdef PRESCALER_SQ_EN
    logic [CH-1:0] e_sq;
`endif
    @(negedge CLK);
    CLR_N   = clr_next;
    CE      = ce;
    SCLR    = sclr;
    DIV_LD  = ld;
    DIV_SEL = sel;
    DIV_IN  = din;
    if (!CLR_N) model_reset();
    #1;
    for (int i = 0; i < CH; i++) begin
      e_ceo[i]  = model_ceo(i);
      e_ack[i]  = m_ack[i];
      e_pend[i] = m_pend[i];
`ifdef PRESCALER_SQ_EN
      e_sq[i]   = m_sq[i];
`endif
    end
    obs_ceo  = CEO;
    obs_ack  = DIV_ACK;
    obs_pend = PEND;
    chk("ceo",  32'(CEO),     32'(e_ceo));
    chk("ack",  32'(DIV_ACK), 32'(e_ack));
    chk("pend", 32'(PEND),    32'(e_pend));
`ifdef PRESCALER_SQ_EN
    chk("sq",   32'(SQ),      32'(e_sq));
`endif
    if (CLR_N) model_edge();
    else       model_reset();
  endtask

  // Cycles between two consecutive CEO pulses on a channel, 0 on timeout.
  task automatic measure_period(input int ch, output int gap);
    int  first;
    bit  done;
    first = -1;
    gap   = 0;
    done  = 1'b0;
    for (int t = 0; t < 64 && !done; t++) begin
      step('1, '0, 1'b0, 2'd0, 8'd0);
      if (obs_ceo[ch]) begin
        if (first < 0) first = t;
        else begin
          gap  = t - first;
          done = 1'b1;
        end
      end
    end
  endtask

  initial begin
    int g;
    int acks;
    logic c0;
    CLR_N = 1'b1; clr_next = 1'b0;
    CE = '0; SCLR = '0; DIV_LD = 1'b0; DIV_SEL = '0; DIV_IN = '0;
    model_reset();
    #1 CLR_N = 1'b0;
    #1;
    chk("rst_pend", 32'(PEND),    32'd0);
    chk("rst_ack",  32'(DIV_ACK), 32'd0);
    chk("rst_ceo",  32'(CEO),     32'd0);
    step('1, '0, 1'b0, 2'd0, 8'd0);
    step('1, '0, 1'b0, 2'd0, 8'd0);

    // Default divide of 5 after release: pulses on cycles 5, 10, 15, 20.
    clr_next = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step('1, '0, 1'b0, 2'd0, 8'd0);
      chk("div5_ceo", 32'(obs_ceo), (k % 5 == 0) ? 32'h7 : 32'h0);
    end

    // Mid-period load of 3 on channel 0 at count 2.
    step('1, '0, 1'b0, 2'd0, 8'd0);
    step('1, '0, 1'b0, 2'd0, 8'd0);
    step('1, '0, 1'b1, 2'd0, 8'd3);
    step('1, '0, 1'b0, 2'd0, 8'd0);
    chk("midload_pend", 32'(obs_pend[0]), 32'd1);
    step('1, '0, 1'b0, 2'd0, 8'd0);
    chk("midload_wrap", 32'(obs_ceo[0]), 32'd1);
    step('1, '0, 1'b0, 2'd0, 8'd0);
    chk("midload_ack", 32'(obs_ack[0]), 32'd1);
    measure_period(0, g);
    chk("period_ch0_3", 32'(g), 32'd3);
    measure_period(1, g);
    chk("period_ch1_5", 32'(g), 32'd5);

    // Zero and one both give a unity divide; CE gates CEO directly.
    step('1, '0, 1'b1, 2'd0, 8'd0);
    measure_period(0, g);
    chk("unity_zero", 32'(g), 32'd1);
    step('1, '0, 1'b1, 2'd0, 8'd1);
    measure_period(0, g);
    chk("unity_one", 32'(g), 32'd1);
    for (int k = 0; k < 16; k++) begin
      c0 = 1'($urandom);
      step({2'b11, c0}, '0, 1'b0, 2'd0, 8'd0);
      chk("unity_gate", 32'(obs_ceo[0]), 32'(c0));
    end

    // Out-of-range select, then overwrite of a pending load.
    step('1, '0, 1'b1, 2'd3, 8'd2);
    step('1, '0, 1'b0, 2'd0, 8'd0);
    chk("oor_pend", 32'(obs_pend), 32'd0);
    step('1, '0, 1'b1, 2'd1, 8'd7);
    step('1, '0, 1'b1, 2'd1, 8'd4);
    acks = 0;
    for (int k = 0; k < 20; k++) begin
      step('1, '0, 1'b0, 2'd0, 8'd0);
      if (obs_ack[1]) acks++;
    end
    chk("single_ack", 32'(acks), 32'd1);
    measure_period(1, g);
    chk("period_ch1_4", 32'(g), 32'd4);

    // Reset while channel 0 holds a pending value at count 3.
    step('1, '0, 1'b1, 2'd0, 8'd6);
    measure_period(0, g);
    chk("period_ch0_6", 32'(g), 32'd6);
    for (int t = 0; t < 16 && m_cnt[0] != 2; t++) step('1, '0, 1'b0, 2'd0, 8'd0);
    step('1, '0, 1'b1, 2'd0, 8'd9);
    step('1, '0, 1'b0, 2'd0, 8'd0);
    chk("prerst_pend", 32'(obs_pend[0]), 32'd1);
    #2 CLR_N = 1'b0;
    clr_next = 1'b0;
    #1;
    chk("midrst_pend", 32'(PEND),    32'd0);
    chk("midrst_ack",  32'(DIV_ACK), 32'd0);
    model_reset();
    step('1, '0, 1'b0, 2'd0, 8'd0);
    step('1, '0, 1'b0, 2'd0, 8'd0);
    clr_next = 1'b1;
    measure_period(0, g);
    chk("postrst_period", 32'(g), 32'd5);

    // Randomized traffic against the model.
    for (int k = 0; k < 1500; k++) begin
      step(($urandom_range(0, 3) == 0) ? CH'($urandom) : '1,
           ($urandom_range(0, 15) == 0) ? CH'($urandom) : '0,
           1'($urandom_range(0, 5) == 0),
           SW'($urandom_range(0, 3)),
           W'($urandom_range(0, 7)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
